// File: rtl/c499_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// c499_ctrl_pkg
// Shared definitions for the c499 key-locked SEC core sequencer:
//   - default widths for key, data word and check bits
//   - controller state encoding
// The package deliberately carries no key value.
// ---------------------------------------------------------------------------
package c499_ctrl_pkg;

  localparam int KEY_W_DEF  = 14;
  localparam int DATA_W_DEF = 32;
  localparam int CHK_W_DEF  = 8;

  typedef enum logic [1:0] {
    LOCKED = 2'd0,
    READY  = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/c499_key_ctrl_if.sv
// ---------------------------------------------------------------------------
// c499_key_ctrl_if
// Request/response bus of the c499 sequencer.
//   req_valid/req_ready : request handshake, payload req_data/req_chk/req_en
//   rsp_valid/rsp_ready : response handshake, payload rsp_data
// Modports:
//   master : requester (drives request, consumes response)
//   slave  : sequencer (accepts request, produces response)
// ---------------------------------------------------------------------------
interface c499_key_ctrl_if
  import c499_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CHK_W  = CHK_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_data;
  logic [CHK_W-1:0]  req_chk;
  logic              req_en;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_data, req_chk, req_en, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, req_chk, req_en, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/c499_key_loader.sv
// ---------------------------------------------------------------------------
// c499_key_loader
// Serial shadow key register with bit counter and commit qualification.
// Build option: C499_KEY_PARITY_EN -- shadow grows by one bit; the last bit
// shifted in is even parity over the key, and a commit additionally needs
// even parity across all shadow bits.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   sin_i          serial key bit
//   shift_i        shift sin_i into the shadow (already gated by the parent)
//   commit_i       commit request (already gated by the parent)
//   key_o          key bits of the shadow register
//   commit_ok_o    pulse: commit accepted this cycle
//   commit_bad_o   pulse: commit rejected this cycle
// ---------------------------------------------------------------------------
module c499_key_loader
  import c499_ctrl_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin_i,
  input  logic             shift_i,
  input  logic             commit_i,
  output logic [KEY_W-1:0] key_o,
  output logic             commit_ok_o,
  output logic             commit_bad_o
);

`ifdef C499_KEY_PARITY_EN
  localparam int SR_W = KEY_W + 1;
`else
  localparam int SR_W = KEY_W;
`endif
  localparam int CNT_W = $clog2(SR_W + 1);

  logic [SR_W-1:0]  shadow_q, shadow_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             parity_ok;

  assign full = (count_q == CNT_W'(SR_W));

`ifdef C499_KEY_PARITY_EN
  // Parity bit sits in the LSB because it is the last bit shifted in.
  assign parity_ok = ~(^shadow_q);
  assign key_o     = shadow_q[SR_W-1:1];
`else
  assign parity_ok = 1'b1;
  assign key_o     = shadow_q;
`endif

  assign commit_ok_o  = commit_i & full & parity_ok;
  assign commit_bad_o = commit_i & ~(full & parity_ok);

  // A commit always restarts the count, accepted or not; the counter
  // saturates so over-long loads keep the most recent SR_W bits.
  always_comb begin
    shadow_d = shadow_q;
    count_d  = count_q;
    if (commit_i) begin
      count_d = '0;
    end else if (shift_i) begin
      shadow_d = {shadow_q[SR_W-2:0], sin_i};
      if (!full) count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      count_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/c499_key_ctrl.sv
// ---------------------------------------------------------------------------
// c499_key_ctrl
// Sequencer for the key-locked c499 single-error-correction core.
// Loads/commits the key serially, forwards one request at a time to the
// combinational core, waits SETTLE_CYC cycles, captures the corrected word
// and returns it on the response port.
// Build option: C499_KEY_PARITY_EN (see c499_key_loader).
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   key_sin/key_sen/key_commit  serial key load and commit
//   key_o/key_ready/key_err     committed key, key present, sticky reject
//   bus (slave)                 request/response handshake bus
//   core_data_o/chk_o/en_o      registered core inputs
//   core_res_i                  core corrected output
// ---------------------------------------------------------------------------
module c499_key_ctrl
  import c499_ctrl_pkg::*;
#(
  parameter int KEY_W      = KEY_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CHK_W      = CHK_W_DEF,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_sin,
  input  logic              key_sen,
  input  logic              key_commit,
  output logic [KEY_W-1:0]  key_o,
  output logic              key_ready,
  output logic              key_err,
  c499_key_ctrl_if.slave    bus,
  output logic [DATA_W-1:0] core_data_o,
  output logic [CHK_W-1:0]  core_chk_o,
  output logic              core_en_o,
  input  logic [DATA_W-1:0] core_res_i
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);

  ctrl_state_e       state_q;
  logic [KEY_W-1:0]  key_q;
  logic              key_ready_q;
  logic              key_err_q;
  logic [DATA_W-1:0] core_data_q;
  logic [CHK_W-1:0]  core_chk_q;
  logic              core_en_q;
  logic [3:0]        settle_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic              key_window;
  logic [KEY_W-1:0]  shadow_key;
  logic              commit_ok;
  logic              commit_bad;

  // Key traffic is only honoured while no request is in flight. A commit
  // in the same cycle as a shift sees the pre-shift shadow; the shift is dropped.
  assign key_window = (state_q == LOCKED) || (state_q == READY);

  c499_key_loader #(.KEY_W(KEY_W)) u_loader (
    .clk          (clk),
    .rst_n        (rst_n),
    .sin_i        (key_sin),
    .shift_i      (key_sen & key_window & ~key_commit),
    .commit_i     (key_commit & key_window),
    .key_o        (shadow_key),
    .commit_ok_o  (commit_ok),
    .commit_bad_o (commit_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOCKED;
      key_q       <= '0;
      key_ready_q <= 1'b0;
      key_err_q   <= 1'b0;
      core_data_q <= '0;
      core_chk_q  <= '0;
      core_en_q   <= 1'b0;
      settle_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      // commit_ok/commit_bad can only fire in LOCKED or READY.
      if (commit_ok) begin
        key_q       <= shadow_key;
        key_ready_q <= 1'b1;
        key_err_q   <= 1'b0;
      end else if (commit_bad) begin
        key_err_q   <= 1'b1;
      end

      case (state_q)
        LOCKED: begin
          if (commit_ok) state_q <= READY;
        end
        READY: begin
          if (bus.req_valid) begin
            core_data_q <= bus.req_data;
            core_chk_q  <= bus.req_chk;
            core_en_q   <= bus.req_en;
            settle_q    <= SETTLE_LOAD;
            state_q     <= SETTLE;
          end
        end
        SETTLE: begin
          // Capture lands exactly SETTLE_CYC edges after the accept edge.
          if (settle_q <= 4'd1) begin
            rsp_data_q  <= core_res_i;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            settle_q    <= settle_q - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= READY;
          end
        end
        default: state_q <= LOCKED;
      endcase
    end
  end

  assign bus.req_ready = (state_q == READY);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign key_o         = key_q;
  assign key_ready     = key_ready_q;
  assign key_err       = key_err_q;
  assign core_data_o   = core_data_q;
  assign core_chk_o    = core_chk_q;
  assign core_en_o     = core_en_q;

endmodule
